// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into words, writes them to instruction RAM and holds the core in reset while loading
module imem_loader #(
   parameter int addr_width = 10,
   parameter int data_width = 32
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  start,
   input  logic [addr_width:0]   len,
   input  logic                  abort,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic [addr_width-1:0] waddr,
   output logic [data_width-1:0] wdata,
   output logic                  we,
   output logic                  busy,
   output logic                  done,
   output logic                  cpu_hold
);
   localparam int BYTES = data_width / 8;
   localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [addr_width:0] DEPTH = {1'b1, {addr_width{1'b0}}};

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   state_t                state_q, state_d;
   logic [BW-1:0]         bcnt_q, bcnt_d;
   logic [addr_width-1:0] wcnt_q, wcnt_d, last_q, last_d, waddr_q, waddr_d;
   logic [data_width-1:0] wdata_q, wdata_d;
   logic                  in_ready_q, in_ready_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
   logic [addr_width:0]   eff_len;
   logic                  last_byte;

   // next state, word assembly and registered-output decode; outputs lag the state by one cycle so abort can still cancel a write
   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      wcnt_d    = wcnt_q;
      last_d    = last_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      eff_len   = (len > DEPTH) ? DEPTH : len;
      last_byte = bcnt_q == BW'(BYTES - 1);
      case (state_q)
         IDLE: if (start && !abort) begin
            last_d  = addr_width'(eff_len - (addr_width + 1)'(1));
            bcnt_d  = '0;
            wcnt_d  = '0;
            state_d = (eff_len != '0) ? COLLECT : DONE;
         end
         COLLECT: if (in_valid && in_ready_q) begin
            wdata_d[{bcnt_q, 3'b000} +: 8] = in_data;
            bcnt_d  = last_byte ? '0 : bcnt_q + BW'(1);
            state_d = last_byte ? WRITE : COLLECT;
         end
         WRITE: begin
            waddr_d = wcnt_q;
            wcnt_d  = (wcnt_q == last_q) ? wcnt_q : wcnt_q + addr_width'(1);
            state_d = (wcnt_q == last_q) ? DONE : COLLECT;
         end
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
      we_d       = (state_q == WRITE) && !abort;
      done_d     = (state_q == DONE) && !abort;
      in_ready_d = (state_d == COLLECT) && (state_q != WRITE);
      busy_d     = (state_d != IDLE) || done_d;
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         bcnt_q     <= '0;
         wcnt_q     <= '0;
         last_q     <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bcnt_q     <= bcnt_d;
         wcnt_q     <= wcnt_d;
         last_q     <= last_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         in_ready_q <= in_ready_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign in_ready = in_ready_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign we       = we_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign cpu_hold = busy_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the instruction memory loader against hand-computed results
module tb_imem_loader;
   logic        CLK = 1'b0;
   logic        RESET_N, start, abort, in_valid;
   logic [10:0] len;
   logic [7:0]  in_data;
   logic        in_ready, we, busy, done, cpu_hold;
   logic [9:0]  waddr;
   logic [31:0] wdata;

   int checks = 0, failures = 0, cyc = 0;
   int n_we = 0, n_we0 = 0, n_done = 0, we_cyc = 0, done_cyc = 0;
   int b_we, b_we0, b_done, s_cyc;
   logic [9:0]  last_addr = '0;
   logic [31:0] mem [0:1023];
   logic [7:0]  bp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

   always #5 CLK = ~CLK;

   imem_loader #(.addr_width(10), .data_width(32)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .start(start), .len(len), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .waddr(waddr),
      .wdata(wdata), .we(we), .busy(busy), .done(done), .cpu_hold(cpu_hold)
   );

   always @(posedge CLK) cyc <= cyc + 1;

   // RAM model behind the write port, plus write/done bookkeeping
   always @(negedge CLK) begin
      if (we) begin
         mem[waddr] = wdata;
         n_we++;
         last_addr = waddr;
         we_cyc = cyc;
         if (waddr == 10'd0) n_we0++;
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k = 0;
      in_valid = 1'b1;
      in_data = b;
      while (!in_ready && k < 20) begin
         step();
         k++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $error("FAIL send_timeout observed in_ready=0 expected 1");
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic wait_done();
      int k = 0;
      while (!done && k < 40) begin
         step();
         k++;
      end
      if (!done) begin
         checks++;
         failures++;
         $error("FAIL done_timeout observed done=0 expected 1");
      end
   endtask

   task automatic start_load(input logic [10:0] l);
      start = 1'b1;
      len = l;
      step();
      start = 1'b0;
   endtask

   initial begin
      RESET_N = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; len = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_outs", {in_ready, we, busy, done, cpu_hold, waddr, wdata}, 64'd0);
      RESET_N = 1'b1;
      step();

      // basic two-word load
      start_load(11'd2);
      chk("busy_rise", {busy, cpu_hold, in_ready}, 3'b111);
      send_word(32'h00000013);
      chk("rdy_in_write", {in_ready, we}, 2'b00);
      send_word(32'h00100093);
      wait_done();
      step();
      chk("basic_nwe", n_we, 2);
      chk("basic_rd0", mem[0], 32'h00000013);
      chk("basic_rd1", mem[1], 32'h00100093);
      chk("basic_done_lat", done_cyc - we_cyc, 1);
      chk("basic_idle", {busy, cpu_hold, done}, 3'b000);
      chk("basic_hold", {waddr, wdata}, {10'd1, 32'h00100093});

      // gaps in the byte stream, exact latency from start to write
      b_we = n_we;
      start_load(11'd1);
      s_cyc = cyc;
      for (int i = 0; i < 7; i++) begin
         in_valid = !i[0];
         in_data = bp[i/2];
         step();
      end
      chk("bp_rdy_write", {in_ready, we}, 2'b00);
      in_valid = 1'b0;
      step();
      chk("bp_we", {we, waddr, wdata}, {1'b1, 10'd0, 32'hDEADBEEF});
      chk("bp_latency", cyc - s_cyc, 8);
      step();
      chk("bp_done", {done, we}, 2'b10);
      step();
      chk("bp_idle", {busy, n_we - b_we}, {1'b0, 32'd1});

      // zero-length load
      b_we = n_we;
      start_load(11'd0);
      chk("zero_busy", {done, busy}, 2'b01);
      step();
      chk("zero_done", {done, we}, 2'b10);
      step();
      chk("zero_idle", {busy, n_we - b_we}, {1'b0, 32'd0});

      // oversize length clamps to memory depth
      b_we = n_we; b_we0 = n_we0; b_done = n_done;
      start_load(11'd1025);
      for (int i = 0; i < 1024; i++) send_word(32'hA5A50000 ^ 32'(i));
      wait_done();
      step();
      chk("clamp_nwe", n_we - b_we, 1024);
      chk("clamp_last", last_addr, 10'd1023);
      chk("clamp_nowrap", n_we0 - b_we0, 1);
      chk("clamp_mem0", mem[0], 32'hA5A50000);
      chk("clamp_mem1023", mem[1023], 32'hA5A503FF);
      chk("clamp_ndone", n_done - b_done, 1);

      // abort in the middle of word 1
      b_we = n_we; b_done = n_done;
      start_load(11'd3);
      send_word(32'h11223344);
      send_byte(8'h55);
      send_byte(8'h66);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", {busy, cpu_hold, in_ready, we}, 4'b0000);
      repeat (5) step();
      chk("abort_nwe", n_we - b_we, 1);
      chk("abort_mem0", mem[0], 32'h11223344);
      chk("abort_mem1", mem[1], 32'hA5A50001);
      chk("abort_nodone", n_done - b_done, 0);
      start_load(11'd1);
      send_word(32'hCAFEF00D);
      wait_done();
      step();
      chk("reload_mem0", {last_addr, mem[0]}, {10'd0, 32'hCAFEF00D});

      // abort coincident with the write cycle
      b_we = n_we; b_done = n_done;
      start_load(11'd1);
      send_word(32'h0BADC0DE);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abortw_outs", {we, busy, done, in_ready}, 4'b0000);
      repeat (3) step();
      chk("abortw_nwe", n_we - b_we, 0);
      chk("abortw_nodone", n_done - b_done, 0);

      // asynchronous reset while word 1 is being collected and word 0 is on the write port
      start_load(11'd2);
      send_word(32'h99887766);
      step();
      chk("pre_rst_we", {we, waddr, wdata}, {1'b1, 10'd0, 32'h99887766});
      #3;
      RESET_N = 1'b0;
      #1;
      chk("async_rst", {in_ready, we, busy, done, cpu_hold, waddr, wdata}, 64'd0);
      #2;
      RESET_N = 1'b1;
      step();
      b_we = n_we;
      start_load(11'd1);
      send_word(32'h04030201);
      wait_done();
      step();
      chk("post_rst_load", {last_addr, mem[0], n_we - b_we}, {10'd0, 32'h04030201, 32'd1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
